// File: rtl/mem_layout_pkg.sv
// mem_layout_pkg: register map, command bit positions and issuer FSM states for the DAC command port.
package mem_layout_pkg;
   localparam logic [1:0] ADDR_CMD        = 2'd0;
   localparam logic [1:0] ADDR_SEED_DATA  = 2'd1;
   localparam logic [1:0] ADDR_SEED_CLR   = 2'd2;
   localparam logic [1:0] ADDR_STATUS_CLR = 2'd3;
   localparam int CMD_RST   = 4;
   localparam int CMD_HALT  = 3;
   localparam int CMD_SHIFT = 2;
   localparam int CMD_TRIG  = 1;
   localparam int CMD_PWL   = 0;
   typedef enum logic [1:0] {IDLE, ISSUE, GAP} issuer_state_t;
endpackage

// File: rtl/dac_cmd_issuer_seed_buffer.sv
// seed_buffer: word-addressed seed register file with wrapping write pointer and full flag.
module seed_buffer #(
   parameter int PS_DATA_WIDTH = 32,
   parameter int BATCH_WIDTH   = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_wr,
   input  logic                     i_clr,
   input  logic [PS_DATA_WIDTH-1:0] i_data,
   output logic [BATCH_WIDTH-1:0]   o_seed,
   output logic                     o_full
);
   localparam int SEED_WORDS = BATCH_WIDTH / PS_DATA_WIDTH;
   localparam int PW = SEED_WORDS > 1 ? $clog2(SEED_WORDS) : 1;
   logic [BATCH_WIDTH-1:0] r_mem;
   logic [PW-1:0]          r_ptr;
   logic                   r_full;
   logic                   w_last;
   assign w_last = r_ptr == PW'(SEED_WORDS - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem  <= '0;
         r_ptr  <= '0;
         r_full <= 1'b0;
      end else if (i_clr) begin
         r_ptr  <= '0;
         r_full <= 1'b0;
      end else if (i_wr) begin
         r_mem[r_ptr*PS_DATA_WIDTH +: PS_DATA_WIDTH] <= i_data;
         r_ptr  <= w_last ? '0 : r_ptr + 1'b1;
         r_full <= r_full | w_last;
      end
   end
   assign o_seed = r_mem;
   assign o_full = r_full;
endmodule

// File: rtl/dac_cmd_issuer.sv
// dac_cmd_issuer: turns PS register writes into {seed, cmd} strobes for the sample generator and captures its responses.
module dac_cmd_issuer
   import mem_layout_pkg::*;
#(
   parameter int CMD_WIDTH     = 5,
   parameter int RESP_WIDTH    = 2,
   parameter int BATCH_WIDTH   = 1024,
   parameter int PS_DATA_WIDTH = 32,
   parameter int ISSUE_GAP     = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [1:0]                       ps_wr_addr,
   input  logic [PS_DATA_WIDTH-1:0]         ps_wr_data,
   input  logic                             ps_wr_valid,
   output logic                             ps_wr_rdy,
   output logic [BATCH_WIDTH+CMD_WIDTH-1:0] ps_cmd,
   output logic                             valid_cmd,
   input  logic [RESP_WIDTH-1:0]            resp,
   input  logic                             resp_valid,
   output logic [RESP_WIDTH-1:0]            last_resp,
   output logic [7:0]                       resp_count,
   output logic                             busy,
   output logic                             seed_full,
   output logic                             cmd_err,
   output logic                             irq
);
   localparam int GW = $clog2(ISSUE_GAP + 1);
   issuer_state_t r_state, w_next;
   logic [GW-1:0]                      r_gap;
   logic [BATCH_WIDTH+CMD_WIDTH-1:0]   r_ps_cmd;
   logic [RESP_WIDTH-1:0]              r_last_resp;
   logic [7:0]                         r_resp_count;
   logic                               r_cmd_err, r_irq;
   logic [BATCH_WIDTH-1:0]             w_seed;
   logic [CMD_WIDTH-1:0]               w_cmd;
   logic                               w_acc, w_cmd_wr, w_bad, w_issue, w_reject;
   logic                               w_seed_wr, w_seed_clr, w_stat_clr, w_multi;
   assign w_acc      = ps_wr_valid && ps_wr_rdy;
   assign w_cmd      = ps_wr_data[CMD_WIDTH-1:0];
   assign w_multi    = ({1'b0, w_cmd[CMD_PWL]} + {1'b0, w_cmd[CMD_TRIG]} + {1'b0, w_cmd[CMD_SHIFT]}) > 2'd1;
   // An rst command bypasses every validity check.
   assign w_bad      = !w_cmd[CMD_RST] && (w_multi || (w_cmd[CMD_SHIFT] && !seed_full));
   assign w_cmd_wr   = w_acc && ps_wr_addr == ADDR_CMD;
   assign w_issue    = w_cmd_wr && !w_bad;
   assign w_reject   = w_cmd_wr && w_bad;
   assign w_seed_wr  = w_acc && ps_wr_addr == ADDR_SEED_DATA;
   assign w_stat_clr = w_acc && ps_wr_addr == ADDR_STATUS_CLR;
   assign w_seed_clr = (w_acc && ps_wr_addr == ADDR_SEED_CLR) ||
                       (w_issue && (w_cmd[CMD_RST] || w_cmd[CMD_HALT]));
   seed_buffer #(.PS_DATA_WIDTH(PS_DATA_WIDTH), .BATCH_WIDTH(BATCH_WIDTH)) u_seed (
      .clk    (clk),
      .rst    (rst),
      .i_wr   (w_seed_wr),
      .i_clr  (w_seed_clr),
      .i_data (ps_wr_data),
      .o_seed (w_seed),
      .o_full (seed_full)
   );
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_issue ? ISSUE : IDLE;
         ISSUE:   w_next = GAP;
         GAP:     w_next = r_gap == GW'(ISSUE_GAP - 1) ? IDLE : GAP;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_gap        <= '0;
         r_ps_cmd     <= '0;
         r_last_resp  <= '0;
         r_resp_count <= '0;
         r_cmd_err    <= 1'b0;
         r_irq        <= 1'b0;
      end else begin
         r_state <= w_next;
         r_gap   <= r_state == GAP ? r_gap + 1'b1 : '0;
         if (w_issue) r_ps_cmd <= {w_seed, w_cmd};
         if (resp_valid) r_last_resp <= resp;
         r_irq <= resp_valid;
         if (w_stat_clr) r_cmd_err <= 1'b0;
         else if (w_reject) r_cmd_err <= 1'b1;
         // A clear coinciding with a response counts that response.
         if (w_stat_clr) r_resp_count <= {7'd0, resp_valid};
         else if (resp_valid && r_resp_count != 8'hff) r_resp_count <= r_resp_count + 8'd1;
      end
   end
   assign ps_wr_rdy  = r_state == IDLE;
   assign busy       = r_state != IDLE;
   assign valid_cmd  = r_state == ISSUE;
   assign ps_cmd     = r_ps_cmd;
   assign last_resp  = r_last_resp;
   assign resp_count = r_resp_count;
   assign cmd_err    = r_cmd_err;
   assign irq        = r_irq;
endmodule

// File: tb/tb_dac_cmd_issuer.sv
// tb_dac_cmd_issuer: directed self-checking bench for dac_cmd_issuer.
module tb_dac_cmd_issuer;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    ps_wr_addr = 2'd0;
   logic [31:0]   ps_wr_data = 32'd0;
   logic          ps_wr_valid = 1'b0;
   logic          ps_wr_rdy;
   logic [1028:0] ps_cmd;
   logic          valid_cmd;
   logic [1:0]    resp = 2'd0;
   logic          resp_valid = 1'b0;
   logic [1:0]    last_resp;
   logic [7:0]    resp_count;
   logic          busy, seed_full, cmd_err, irq;
   int            n_vec = 0;
   int            n_err = 0;
   always #5 clk = ~clk;
   dac_cmd_issuer dut (
      .clk         (clk),
      .rst         (rst),
      .ps_wr_addr  (ps_wr_addr),
      .ps_wr_data  (ps_wr_data),
      .ps_wr_valid (ps_wr_valid),
      .ps_wr_rdy   (ps_wr_rdy),
      .ps_cmd      (ps_cmd),
      .valid_cmd   (valid_cmd),
      .resp        (resp),
      .resp_valid  (resp_valid),
      .last_resp   (last_resp),
      .resp_count  (resp_count),
      .busy        (busy),
      .seed_full   (seed_full),
      .cmd_err     (cmd_err),
      .irq         (irq)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      ps_wr_addr  = a;
      ps_wr_data  = d;
      ps_wr_valid = 1'b1;
      tick();
      ps_wr_valid = 1'b0;
   endtask
   task automatic wait_idle();
      int n;
      n = 0;
      while (!ps_wr_rdy && n < 10) begin
         tick();
         n++;
      end
      chk("wait_idle", {31'd0, ps_wr_rdy}, 32'd1);
   endtask
   initial begin
      tick();
      tick();
      rst = 1'b0;
      chk("rst_rdy", {31'd0, ps_wr_rdy}, 32'd1);
      chk("rst_valid", {31'd0, valid_cmd}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_full", {31'd0, seed_full}, 32'd0);
      chk("rst_err", {31'd0, cmd_err}, 32'd0);
      chk("rst_cnt", {24'd0, resp_count}, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_cmd", {27'd0, ps_cmd[4:0]}, 32'd0);
      // CMD 0x02 issue timing
      wr(2'd0, 32'h02);
      chk("t1_valid", {31'd0, valid_cmd}, 32'd1);
      chk("t1_cmd", {27'd0, ps_cmd[4:0]}, 32'h02);
      chk("t1_rdy", {31'd0, ps_wr_rdy}, 32'd0);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("t2_valid", {31'd0, valid_cmd}, 32'd0);
      chk("t2_rdy", {31'd0, ps_wr_rdy}, 32'd0);
      tick();
      chk("t3_rdy", {31'd0, ps_wr_rdy}, 32'd0);
      tick();
      chk("t4_rdy", {31'd0, ps_wr_rdy}, 32'd1);
      chk("t4_busy", {31'd0, busy}, 32'd0);
      chk("t4_cmd_hold", {27'd0, ps_cmd[4:0]}, 32'h02);
      // shift without seed is rejected
      wr(2'd0, 32'h04);
      chk("noseed_valid", {31'd0, valid_cmd}, 32'd0);
      chk("noseed_err", {31'd0, cmd_err}, 32'd1);
      chk("noseed_busy", {31'd0, busy}, 32'd0);
      wr(2'd3, 32'h0);
      chk("statclr_err", {31'd0, cmd_err}, 32'd0);
      // load 32 seed words
      for (int k = 0; k < 31; k++) wr(2'd1, k);
      chk("seed31_full", {31'd0, seed_full}, 32'd0);
      wr(2'd1, 32'd31);
      chk("seed32_full", {31'd0, seed_full}, 32'd1);
      wr(2'd0, 32'h04);
      chk("shift_valid", {31'd0, valid_cmd}, 32'd1);
      chk("shift_cmd", {27'd0, ps_cmd[4:0]}, 32'h04);
      for (int k = 0; k < 32; k++) chk($sformatf("seed_w%0d", k), ps_cmd[5+32*k +: 32], k);
      wait_idle();
      chk("shift_full_kept", {31'd0, seed_full}, 32'd1);
      // multi-run rejection, rst override
      wr(2'd0, 32'h03);
      chk("multi_err", {31'd0, cmd_err}, 32'd1);
      chk("multi_valid", {31'd0, valid_cmd}, 32'd0);
      wr(2'd0, 32'h13);
      chk("rstcmd_valid", {31'd0, valid_cmd}, 32'd1);
      chk("rstcmd_cmd", {27'd0, ps_cmd[4:0]}, 32'h13);
      chk("rstcmd_full", {31'd0, seed_full}, 32'd0);
      chk("rstcmd_seed5", ps_cmd[5+32*5 +: 32], 32'd5);
      wait_idle();
      wr(2'd3, 32'h0);
      // response capture
      resp_valid = 1'b1;
      resp = 2'd1;
      tick();
      chk("r1_cnt", {24'd0, resp_count}, 32'd1);
      chk("r1_last", {30'd0, last_resp}, 32'd1);
      chk("r1_irq", {31'd0, irq}, 32'd1);
      resp = 2'd0;
      tick();
      chk("r2_cnt", {24'd0, resp_count}, 32'd2);
      chk("r2_last", {30'd0, last_resp}, 32'd0);
      chk("r2_irq", {31'd0, irq}, 32'd1);
      resp = 2'd1;
      tick();
      chk("r3_cnt", {24'd0, resp_count}, 32'd3);
      chk("r3_last", {30'd0, last_resp}, 32'd1);
      chk("r3_irq", {31'd0, irq}, 32'd1);
      resp_valid = 1'b0;
      tick();
      chk("r4_irq", {31'd0, irq}, 32'd0);
      chk("r4_cnt", {24'd0, resp_count}, 32'd3);
      // clear racing a response
      wr(2'd0, 32'h06);
      chk("race_pre_err", {31'd0, cmd_err}, 32'd1);
      resp_valid = 1'b1;
      wr(2'd3, 32'h0);
      resp_valid = 1'b0;
      chk("race_err", {31'd0, cmd_err}, 32'd0);
      chk("race_cnt", {24'd0, resp_count}, 32'd1);
      // saturation
      resp_valid = 1'b1;
      for (int k = 0; k < 300; k++) tick();
      resp_valid = 1'b0;
      chk("sat_cnt", {24'd0, resp_count}, 32'd255);
      // reset during GAP
      wr(2'd0, 32'h01);
      chk("g_valid", {31'd0, valid_cmd}, 32'd1);
      tick();
      chk("g_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("grst_rdy", {31'd0, ps_wr_rdy}, 32'd1);
      chk("grst_busy", {31'd0, busy}, 32'd0);
      chk("grst_valid", {31'd0, valid_cmd}, 32'd0);
      chk("grst_cnt", {24'd0, resp_count}, 32'd0);
      chk("grst_last", {30'd0, last_resp}, 32'd0);
      chk("grst_cmd", {27'd0, ps_cmd[4:0]}, 32'd0);
      chk("grst_err", {31'd0, cmd_err}, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/dac_cmd_issuer.md
# dac_cmd_issuer

Issuing side of the sample-generator command port. Converts PS register writes (one 32-bit word per write) into the wide `{seed, cmd}` word and a one-cycle `valid_cmd` strobe for the DAC sample generator. Captures the generator's `resp`/`resp_valid` back into PS-readable status, with an interrupt pulse. Sits between the PS register slave and the sample generator in the DAC path.

## Interface
- `CMD_WIDTH`, 5: command field width; bits are [4]=rst, [3]=halt, [2]=run_shift_regs, [1]=run_trig_wave, [0]=run_pwl.
- `RESP_WIDTH`, 2: generator response width; bit 0 = pwl_rdy.
- `BATCH_WIDTH`, 1024: seed field width (one batch of samples).
- `PS_DATA_WIDTH`, 32: PS write word width; BATCH_WIDTH must be a multiple of it.
- `ISSUE_GAP`, 2: cycles with `ps_wr_rdy` low after each `valid_cmd`; legal range ≥1.
- `clk`  in  1  clock; the only clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `ps_wr_addr`  in  2  register select: 0=CMD, 1=SEED_DATA, 2=SEED_CLR, 3=STATUS_CLR.
- `ps_wr_data`  in  PS_DATA_WIDTH  write payload.
- `ps_wr_valid`  in  1  write request.
- `ps_wr_rdy`  out  1  write accepted when `ps_wr_valid && ps_wr_rdy`.
- `ps_cmd`  out  BATCH_WIDTH+CMD_WIDTH  `{seed, cmd}`; seed word k sits at bits `[CMD_WIDTH+PS_DATA_WIDTH*k +: PS_DATA_WIDTH]`.
- `valid_cmd`  out  1  one-cycle command strobe.
- `resp`  in  RESP_WIDTH  generator response.
- `resp_valid`  in  1  response strobe.
- `last_resp`  out  RESP_WIDTH  most recent captured response.
- `resp_count`  out  8  saturating count of responses.
- `busy`  out  1  FSM not in IDLE.
- `seed_full`  out  1  all SEED_WORDS words written since the last clear.
- `cmd_err`  out  1  sticky error flag.
- `irq`  out  1  one-cycle pulse per captured response.

## Operation
- SEED_WORDS = BATCH_WIDTH/PS_DATA_WIDTH. Pointer width is `$clog2(SEED_WORDS)`.
- SEED_DATA write:
  - Stores the word at the pointer, then increments the pointer.
  - Writing the last word sets `seed_full` and wraps the pointer to 0.
  - Later writes overwrite from word 0; `seed_full` stays set.
- SEED_CLR write: pointer ← 0, `seed_full` ← 0. The buffer contents are kept.
- STATUS_CLR write: `cmd_err` ← 0, `resp_count` ← 0.
- CMD write, using `ps_wr_data[CMD_WIDTH-1:0]`. Rejected (no issue, `cmd_err` ← 1) when either holds:
  - more than one of bits [2:0] is set;
  - bit 2 is set while `seed_full` = 0.
  - Rejection does not apply when bit 4 (rst) is set: an rst command is always issued.
- On an accepted CMD write:
  - `ps_cmd` ← `{seed_buffer, cmd}` and the FSM enters ISSUE.
  - If bit 4 or bit 3 is set, the pointer and `seed_full` are also cleared.
- Unknown addresses do not exist; all four codes are defined.
- FSM:
  - IDLE: `ps_wr_rdy`=1. An accepted CMD write goes to ISSUE.
  - ISSUE: `valid_cmd`=1 for exactly one cycle, then GAP.
  - GAP: count ISSUE_GAP cycles, then IDLE. `ps_wr_rdy`=0 in both ISSUE and GAP.
- Response capture runs independently of the FSM. On `resp_valid`:
  - `last_resp` ← `resp`;
  - `resp_count` ← `resp_count`+1, saturating at 255;
  - `irq` pulses on the next cycle.

## Timing
- Reset values:
  - `ps_cmd`, `valid_cmd`, `last_resp`, `resp_count`, `busy`, `seed_full`, `cmd_err`, `irq` = 0.
  - `ps_wr_rdy` = 1; pointer = 0; FSM = IDLE.
  - The seed buffer is cleared.
- CMD accepted at cycle t:
  - `ps_cmd` valid and `valid_cmd`=1 at t+1.
  - `ps_wr_rdy`=0 from t+1 through t+1+ISSUE_GAP; back to 1 at t+2+ISSUE_GAP.
  - `ps_cmd` holds its value until the next accepted command.
- A rejected CMD sets `cmd_err` at t+1; the FSM stays in IDLE.
- A SEED write at t is visible in the buffer/pointer at t+1. `seed_full` rises at t+1 after the last word.
- `resp_valid` at t: `last_resp`/`resp_count` update at t+1 and `irq`=1 at t+1. A `resp_valid` on consecutive cycles gives a count per cycle and back-to-back `irq`.
- A STATUS_CLR in the same cycle as `resp_valid`: the clear wins for `cmd_err`; `resp_count` ends at 1.
- `rst` mid-ISSUE/GAP: all state returns to reset values on the next edge. `valid_cmd` is 0 from that edge onward.

## Structure
- Shared package `mem_layout_pkg` holds:
  - the register address constants (CMD/SEED_DATA/SEED_CLR/STATUS_CLR);
  - the cmd bit positions;
  - the FSM state enum `issuer_state_t` {IDLE, ISSUE, GAP}.
- One sub-module, `seed_buffer`: a SEED_WORDS×PS_DATA_WIDTH register file with write pointer, wrap and `seed_full`, plus a flat BATCH_WIDTH output.

## Test plan
- After reset, CMD write 0x02 -> `valid_cmd` pulses at t+1 with `ps_cmd[4:0]`=0x02; `ps_wr_rdy` is low for 3 cycles; `busy` is low at t+4.
- CMD 0x04 with no seed loaded -> no `valid_cmd`; `cmd_err`=1. STATUS_CLR clears it.
- Write 32 SEED words with values 0..31, then CMD 0x04 -> `seed_full`=1; `ps_cmd` word k at bits [5+32k+:32] equals k.
- CMD 0x03 -> rejected with `cmd_err`. CMD 0x13 -> issued (rst overrides) and `seed_full` cleared.
- Three `resp_valid` pulses with `resp`=1,0,1 -> `resp_count`=3, `last_resp`=1, three `irq` pulses; 300 pulses -> `resp_count`=255.
- Assert `rst` during GAP -> next cycle `ps_wr_rdy`=1, `busy`=0, all status 0.
